datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 8, which sets the bus, register, RAM word and output width.
REQ-002 The block SHALL have the parameter ADDR_W, default 4, which sets the PC, MAR and RAM address width (2**ADDR_W words).
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have the port ctrl_data, input, 16 bits, the control word: bit15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
REQ-006 The block SHALL have the port instruction, output, 4 bits, the IR upper nibble (opcode) fed back to the control unit.
REQ-007 The block SHALL have the ports prog_we (input, 1), prog_addr (input, ADDR_W) and prog_data (input, DATA_W), the RAM preload port.
REQ-008 The block SHALL have the ports out_data (output, DATA_W), the output register, and out_valid (output, 1), a 1-cycle pulse on each OI load.
REQ-009 The block SHALL have the ports flag_c and flag_z (output, 1 each), the latched carry and zero flags.
REQ-010 The block SHALL have the port halted (output, 1), which is sticky high after HLT.
REQ-011 The block SHALL have the port bus_conflict (output, 1), a registered 1-cycle pulse when more than one bus driver is asserted.

Function
REQ-012 The bus SHALL be combinational, with drivers CO (PC zero-extended), RO (RAM[MAR]), IO (IR[3:0] zero-extended), AO (A) and EO (ALU result).
REQ-013 With no driver asserted, the bus SHALL be 0; with two or more drivers, the bus SHALL be 0 and bus_conflict SHALL pulse on the next cycle.
REQ-014 ctrl_data SHALL be sampled at each rising clk edge, and loads SHALL be visible on outputs on the following cycle (latency 1).
REQ-015 MI SHALL load MAR<=bus[ADDR_W-1:0]; II SHALL load IR<=bus; AI SHALL load A<=bus; BI SHALL load B<=bus; OI SHALL load OUT<=bus and pulse out_valid; RI SHALL write RAM[MAR]<=bus.
REQ-016 A register SHALL load with bus contents from the same cycle; for example, with AO|AI the value of A SHALL be unchanged.
REQ-017 The ALU SHALL compute A+B when SU=0 and A+(~B)+1 when SU=1, over DATA_W+1 bits; carry SHALL be bit DATA_W, and zero SHALL be (result[DATA_W-1:0]==0).
REQ-018 FI SHALL latch carry and zero into flag_c and flag_z; without FI, the flags SHALL hold.
REQ-019 CE SHALL increment the PC modulo 2**ADDR_W (15 wraps to 0); J SHALL load PC<=bus[ADDR_W-1:0]; when J and CE are both set, J SHALL win.
REQ-020 HLT SHALL set halted on the next cycle; while halted, all ctrl_data bits SHALL be ignored and all registers and flags SHALL hold.
REQ-021 prog_we SHALL be honoured only when rst=1 or halted=1, writing RAM[prog_addr]<=prog_data; otherwise it SHALL be ignored.
REQ-022 RI and prog_we SHALL never both take effect in one cycle, because RI is inactive under rst or halted.

Reset
REQ-023 rst SHALL clear A, B, PC, MAR, IR, OUT, flag_c, flag_z, halted, out_valid and bus_conflict to 0 on the next rising edge, overriding ctrl_data.
REQ-024 RAM contents SHALL NOT be cleared by rst.
REQ-025 rst asserted mid-program SHALL abort the transfer in progress with no partial register update.
REQ-026 rst SHALL be the only exit from halted.

Structure
REQ-027 A shared package eater_pkg SHALL hold the 16 control-bit index constants, the opcode constants, and DATA_W/ADDR_W defaults, shared with the control unit.
REQ-028 One sub-module, eater_alu (combinational add/sub with carry and zero), SHALL be instantiated.
REQ-029 The RAM SHALL be an inferred register array inside datapath.

Verification
REQ-030 The bench SHALL cover fetch: PC=0, RAM[0]=0x1E, cycle MI|CO then RO|II|CE -> IR=0x1E, instruction=1, PC=1.
REQ-031 The bench SHALL cover ADD: A=0x0F, B=0xF1, EO|AI|FI -> A=0x00, flag_c=1, flag_z=1.
REQ-032 The bench SHALL cover SUB: A=5, B=7, EO|AI|SU|FI -> A=0xFE, flag_c=0, flag_z=0; a following cycle without FI -> flags unchanged.
REQ-033 The bench SHALL cover PC behaviour: PC=15 with CE -> PC=0; IR=0x63 with IO|J|CE -> PC=3.
REQ-034 The bench SHALL cover conflict: AO|RO with RAM[MAR]=0x55 and A=0xAA, plus BI -> B=0x00 and bus_conflict pulses once.
REQ-035 The bench SHALL cover halt: A=0x2A, AO|OI -> out_data=0x2A with a 1-cycle out_valid; then HLT -> halted=1, later AI ignored, prog_we writes RAM, rst clears halted with RAM retained.

Source files
------------

// File: rtl/eater_pkg.sv
// Shared constants for the 8-bit breadboard-style CPU.
// Control-word bit positions, opcodes and default widths.
package eater_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    localparam int CB_HLT = 15;
    localparam int CB_MI  = 14;
    localparam int CB_RI  = 13;
    localparam int CB_RO  = 12;
    localparam int CB_IO  = 11;
    localparam int CB_II  = 10;
    localparam int CB_AI  = 9;
    localparam int CB_AO  = 8;
    localparam int CB_EO  = 7;
    localparam int CB_SU  = 6;
    localparam int CB_BI  = 5;
    localparam int CB_OI  = 4;
    localparam int CB_CE  = 3;
    localparam int CB_CO  = 2;
    localparam int CB_J   = 1;
    localparam int CB_FI  = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/datapath_if.sv
// Control unit <-> datapath bundle: control word in,
// status/output back, plus the RAM preload port.
interface datapath_if
    import eater_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [15:0]       ctrl_data;
    logic [3:0]        instruction;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              flag_c;
    logic              flag_z;
    logic              halted;
    logic              bus_conflict;

    modport master (
        output ctrl_data, prog_we, prog_addr, prog_data,
        input  instruction, out_data, out_valid,
        input  flag_c, flag_z, halted, bus_conflict
    );

    modport slave (
        input  ctrl_data, prog_we, prog_addr, prog_data,
        output instruction, out_data, out_valid,
        output flag_c, flag_z, halted, bus_conflict
    );

endinterface

// File: rtl/eater_alu.sv
// Combinational add/subtract with carry-out and zero detect.
module eater_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   sum;

    // Subtraction is two's complement: A + ~B + 1
    assign b_op = sub_i ? ~b_i : b_i;
    assign sum  = {1'b0, a_i} + {1'b0, b_op} + (DATA_W+1)'(sub_i);

    assign result_o = sum[DATA_W-1:0];
    assign carry_o  = sum[DATA_W];
    assign zero_o   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: A/B/ALU, PC, MAR, IR, OUT, flags and RAM,
// all steered by a 16-bit control word from the control unit.
module datapath
    import eater_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic       clk,
    input logic       rst,
    datapath_if.slave dp
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic              fc_q, fc_d;
    logic              fz_q, fz_d;
    logic              halted_q, halted_d;
    logic              ov_q, ov_d;
    logic              bc_q, bc_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              active;
    logic [15:0]       c;
    logic [4:0]        drv;
    logic              multi;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;

    // Reset and halt both mask the whole control word
    assign active = !rst && !halted_q;
    assign c      = active ? dp.ctrl_data : 16'h0000;

    assign drv = {c[CB_CO], c[CB_RO], c[CB_IO], c[CB_AO], c[CB_EO]};
    assign multi = ($countones(drv) > 1);

    assign ram_rd = mem_q[mar_q];

    eater_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .sub_i    (c[CB_SU]),
        .result_o (alu_res),
        .carry_o  (alu_c),
        .zero_o   (alu_z)
    );

    always_comb begin
        bus = '0;
        if (!multi) begin
            unique case (1'b1)
                c[CB_CO]: bus = DATA_W'(pc_q);
                c[CB_RO]: bus = ram_rd;
                c[CB_IO]: bus = DATA_W'(ir_q[3:0]);
                c[CB_AO]: bus = a_q;
                c[CB_EO]: bus = alu_res;
                default:  bus = '0;
            endcase
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        ir_d     = ir_q;
        out_d    = out_q;
        pc_d     = pc_q;
        mar_d    = mar_q;
        fc_d     = fc_q;
        fz_d     = fz_q;
        halted_d = halted_q | c[CB_HLT];
        ov_d     = c[CB_OI];
        bc_d     = multi;

        if (c[CB_AI]) a_d   = bus;
        if (c[CB_BI]) b_d   = bus;
        if (c[CB_II]) ir_d  = bus;
        if (c[CB_OI]) out_d = bus;
        if (c[CB_MI]) mar_d = bus[ADDR_W-1:0];

        // Jump has priority over increment
        if (c[CB_J])
            pc_d = bus[ADDR_W-1:0];
        else if (c[CB_CE])
            pc_d = pc_q + 1'b1;

        if (c[CB_FI]) begin
            fc_d = alu_c;
            fz_d = alu_z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            ir_q     <= '0;
            out_q    <= '0;
            pc_q     <= '0;
            mar_q    <= '0;
            fc_q     <= 1'b0;
            fz_q     <= 1'b0;
            halted_q <= 1'b0;
            ov_q     <= 1'b0;
            bc_q     <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            ir_q     <= ir_d;
            out_q    <= out_d;
            pc_q     <= pc_d;
            mar_q    <= mar_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
            halted_q <= halted_d;
            ov_q     <= ov_d;
            bc_q     <= bc_d;
        end
    end

    // RAM keeps its contents across reset; preload only while stopped
    always_ff @(posedge clk) begin
        if ((rst || halted_q) && dp.prog_we)
            mem_q[dp.prog_addr] <= dp.prog_data;
        else if (c[CB_RI])
            mem_q[mar_q] <= bus;
    end

    assign dp.instruction  = ir_q[DATA_W-1 -: 4];
    assign dp.out_data     = out_q;
    assign dp.out_valid    = ov_q;
    assign dp.flag_c       = fc_q;
    assign dp.flag_z       = fz_q;
    assign dp.halted       = halted_q;
    assign dp.bus_conflict = bc_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: fetch, ALU, PC, bus conflict,
// output, halt and RAM preload/retention.
module tb_datapath;

    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0] img [16] = '{
        8'h1E, 8'h0F, 8'hF1, 8'h05, 8'h07, 8'h63, 8'hAA, 8'h55,
        8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    datapath_if #(.DATA_W(8), .ADDR_W(4)) dp ();

    datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [15:0] cw);
        dp.ctrl_data = cw;
        @(posedge clk);
        #1;
        dp.ctrl_data = 16'h0000;
    endtask

    initial begin
        dp.ctrl_data = 16'hFFFF;
        dp.prog_we   = 1'b0;
        dp.prog_addr = '0;
        dp.prog_data = '0;

        // Preload RAM under reset with every control bit set
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dp.prog_we   = 1'b1;
            dp.prog_addr = 4'(i);
            dp.prog_data = img[i];
            @(posedge clk);
            #1;
        end
        dp.prog_we   = 1'b0;
        dp.ctrl_data = 16'h0000;
        rst = 1'b0;

        check("rst_instr", 32'(dp.instruction), 32'h0);
        check("rst_out", 32'(dp.out_data), 32'h00);
        check("rst_ov", 32'(dp.out_valid), 32'h0);
        check("rst_fc", 32'(dp.flag_c), 32'h0);
        check("rst_fz", 32'(dp.flag_z), 32'h0);
        check("rst_halt", 32'(dp.halted), 32'h0);
        check("rst_bc", 32'(dp.bus_conflict), 32'h0);
        check("rst_pc", 32'(dut.pc_q), 32'h0);
        check("rst_a", 32'(dut.a_q), 32'h00);

        // Fetch
        step(MI | CO);
        step(RO | II | CE);
        check("fetch_ir", 32'(dut.ir_q), 32'h1E);
        check("fetch_instr", 32'(dp.instruction), 32'h1);
        check("fetch_pc", 32'(dut.pc_q), 32'h1);

        // ADD 0x0F + 0xF1
        step(CO | MI);
        step(RO | AI | CE);
        step(CO | MI);
        step(RO | BI | CE);
        check("add_b", 32'(dut.b_q), 32'hF1);
        step(EO | AI | FI);
        check("add_a", 32'(dut.a_q), 32'h00);
        check("add_c", 32'(dp.flag_c), 32'h1);
        check("add_z", 32'(dp.flag_z), 32'h1);

        // SUB 5 - 7, then an ADD without FI
        step(CO | MI);
        step(RO | AI | CE);
        step(CO | MI);
        step(RO | BI | CE);
        step(EO | AI | SU | FI);
        check("sub_a", 32'(dut.a_q), 32'hFE);
        check("sub_c", 32'(dp.flag_c), 32'h0);
        check("sub_z", 32'(dp.flag_z), 32'h0);
        step(EO | AI);
        check("nofi_a", 32'(dut.a_q), 32'h05);
        check("nofi_c", 32'(dp.flag_c), 32'h0);
        check("nofi_z", 32'(dp.flag_z), 32'h0);

        // J beats CE; then wrap from 15
        step(CO | MI);
        step(RO | II | CE);
        check("jmp_instr", 32'(dp.instruction), 32'h6);
        check("pre_jmp_pc", 32'(dut.pc_q), 32'h6);
        step(IO | J | CE);
        check("jmp_pc", 32'(dut.pc_q), 32'h3);
        for (int i = 0; i < 12; i++) step(CE);
        check("pc15", 32'(dut.pc_q), 32'hF);
        step(CE);
        check("pc_wrap", 32'(dut.pc_q), 32'h0);

        // Bus conflict: AO|RO with A=0xAA, RAM[7]=0x55
        for (int i = 0; i < 6; i++) step(CE);
        step(CO | MI);
        step(RO | AI | CE);
        step(CO | MI);
        check("conf_a", 32'(dut.a_q), 32'hAA);
        check("conf_bc0", 32'(dp.bus_conflict), 32'h0);
        step(AO | RO | BI);
        check("conf_b", 32'(dut.b_q), 32'h00);
        check("conf_bc1", 32'(dp.bus_conflict), 32'h1);
        step(16'h0000);
        check("conf_bc2", 32'(dp.bus_conflict), 32'h0);
        step(AO | AI);
        check("aoai_a", 32'(dut.a_q), 32'hAA);

        // Output, then halt; prog_we must be ignored while running
        step(CE);
        step(CO | MI);
        dp.prog_we   = 1'b1;
        dp.prog_addr = 4'h8;
        dp.prog_data = 8'h11;
        step(RO | AI);
        dp.prog_we   = 1'b0;
        check("ld_a", 32'(dut.a_q), 32'h2A);
        step(AO | OI);
        check("out_data", 32'(dp.out_data), 32'h2A);
        check("out_v1", 32'(dp.out_valid), 32'h1);
        step(16'h0000);
        check("out_v0", 32'(dp.out_valid), 32'h0);
        check("out_hold", 32'(dp.out_data), 32'h2A);
        step(HLT);
        check("halt1", 32'(dp.halted), 32'h1);
        dp.prog_we   = 1'b1;
        dp.prog_addr = 4'h3;
        dp.prog_data = 8'h99;
        step(RO | AI | CE | FI);
        dp.prog_we   = 1'b0;
        check("halt_a", 32'(dut.a_q), 32'h2A);
        check("halt_pc", 32'(dut.pc_q), 32'h8);
        check("halt_c", 32'(dp.flag_c), 32'h0);
        check("halt_stay", 32'(dp.halted), 32'h1);

        // Reset leaves halt; RAM keeps preload and earlier contents
        rst = 1'b1;
        step(16'h0000);
        rst = 1'b0;
        check("rel_halt", 32'(dp.halted), 32'h0);
        check("rel_a", 32'(dut.a_q), 32'h00);
        check("rel_out", 32'(dp.out_data), 32'h00);
        for (int i = 0; i < 3; i++) step(CE);
        step(CO | MI);
        step(RO | OI);
        check("ram3", 32'(dp.out_data), 32'h99);
        check("ram3_v", 32'(dp.out_valid), 32'h1);
        for (int i = 0; i < 5; i++) step(CE);
        step(CO | MI);
        step(RO | OI);
        check("ram8", 32'(dp.out_data), 32'h2A);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
